// File: rtl/sitcp_tx_pkg.sv
// rtl/sitcp_tx_pkg.sv - shared constants and types for the SiTCP TX multiplexer
//
// Holds the frame header marker, the header length and the framer FSM states
// used by sitcp_tx_mux. Also provides an index-width helper that stays legal
// for a single-channel build.
package sitcp_tx_pkg;

  localparam logic [7:0] HDR_MARKER = 8'hA5;
  localparam int         HDR_LEN    = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    HDR2 = 3'd3,
    DATA = 3'd4
  } tx_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sitcp_sync_fifo.sv
// rtl/sitcp_sync_fifo.sv - single-clock FIFO with occupancy count
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   flush     synchronous clear of pointers and count (contents are don't-care)
//   wr_en     write request; accepted only while count < DEPTH
//   wr_data   write data
//   rd_en     read request; accepted only while count != 0
//   rd_data   head-of-queue data, valid combinationally while count != 0
//   count     occupancy 0..DEPTH, updated once per clock
module sitcp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance uses the count from before this cycle's read, so a write to a
  // full FIFO is refused even if a read frees a slot in the same cycle.
  assign wr_ok   = wr_en && !flush && (count < FULL_CNT);
  assign rd_ok   = rd_en && !flush && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sitcp_tx_mux.sv
// rtl/sitcp_tx_mux.sv - round-robin byte-channel multiplexer into the SiTCP TX port
//
// Ports:
//   CLK, RST       CLK_200M domain clock, asynchronous active-high reset
//   TCP_OPEN_ACK   connection open; while low all FIFOs, overflow flags and
//                  the framer are flushed
//   CH_DATA/CH_WE  per-channel byte writes, channel k on CH_DATA[8k+7:8k]
//   CH_AFULL       count >= DEPTH-AFULL_MARGIN, per channel
//   CH_OVF         sticky: a write arrived while the channel FIFO was full
//   TCP_TX_FULL    SiTCP back-pressure; the framer freezes while high
//   TCP_TX_WR/DATA registered byte stream into SiTCP
//
// Build option SITCP_TX_MUX_HDR_EN: prefix each frame with
// {HDR_MARKER, channel, LEN-1}. Without it frames carry payload only.
module sitcp_tx_mux
  import sitcp_tx_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEPTH        = 1024,
  parameter int BURST        = 256,
  parameter int AFULL_MARGIN = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TCP_OPEN_ACK,
  input  logic [8*N_CH-1:0] CH_DATA,
  input  logic [N_CH-1:0]   CH_WE,
  output logic [N_CH-1:0]   CH_AFULL,
  output logic [N_CH-1:0]   CH_OVF,
  input  logic              TCP_TX_FULL,
  output logic              TCP_TX_WR,
  output logic [7:0]        TCP_TX_DATA
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam int            IW        = idx_width(N_CH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - AFULL_MARGIN);

`ifdef SITCP_TX_MUX_HDR_EN
  localparam tx_state_t FIRST_ST = HDR0;
`else
  localparam tx_state_t FIRST_ST = DATA;
`endif

  logic [CW-1:0]   fifo_cnt  [N_CH];
  logic [7:0]      fifo_dout [N_CH];
  logic [N_CH-1:0] fifo_rd;

  tx_state_t       state;
  tx_state_t       state_nx;
  logic [IW-1:0]   gnt_ch;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick_ch;
  logic            pick_vld;
  logic [8:0]      pick_len;
  logic [8:0]      len;
  logic [8:0]      rem;
  logic            step;
  logic            grant;
  logic            emit;
  logic [7:0]      emit_byte;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    sitcp_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .flush   (!TCP_OPEN_ACK),
      .wr_en   (CH_WE[k] && TCP_OPEN_ACK),
      .wr_data (CH_DATA[8*k +: 8]),
      .rd_en   (fifo_rd[k]),
      .rd_data (fifo_dout[k]),
      .count   (fifo_cnt[k])
    );
    assign CH_AFULL[k] = (fifo_cnt[k] >= AFULL_CNT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CH_OVF <= '0;
    end else if (!TCP_OPEN_ACK) begin
      CH_OVF <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (CH_WE[k] && (fifo_cnt[k] == FULL_CNT)) CH_OVF[k] <= 1'b1;
      end
    end
  end

  // Round-robin search starting one past the previous grant.
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick_ch  = '0;
    idx      = 0;
    cand     = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = IW'(idx);
      if (!pick_vld && (fifo_cnt[cand] != '0)) begin
        pick_vld = 1'b1;
        pick_ch  = cand;
      end
    end
  end

  assign pick_len = (int'(fifo_cnt[pick_ch]) > BURST) ? 9'(BURST) : 9'(fifo_cnt[pick_ch]);

  // Every FSM move, grant included, waits for SiTCP to accept a byte, so a
  // channel written while back-pressured is framed with its full backlog.
  assign step  = TCP_OPEN_ACK && !TCP_TX_FULL;
  assign grant = step && (state == IDLE) && pick_vld;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!TCP_OPEN_ACK) begin
      state_nx = IDLE;
    end else if (!TCP_TX_FULL) begin
      case (state)
        IDLE:    if (pick_vld) state_nx = FIRST_ST;
        HDR0:    state_nx = HDR1;
        HDR1:    state_nx = HDR2;
        HDR2:    state_nx = DATA;
        DATA:    if (rem == 9'd1) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_byte = 8'h00;
    fifo_rd   = '0;
    if (step) begin
      case (state)
        HDR0: begin
          emit      = 1'b1;
          emit_byte = HDR_MARKER;
        end
        HDR1: begin
          emit      = 1'b1;
          emit_byte = {4'h0, 4'(gnt_ch)};
        end
        HDR2: begin
          emit      = 1'b1;
          emit_byte = 8'(len - 9'd1);
        end
        DATA: begin
          emit            = 1'b1;
          emit_byte       = fifo_dout[gnt_ch];
          fifo_rd[gnt_ch] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_ch     <= '0;
      last_grant <= IW'(N_CH - 1);
      len        <= '0;
      rem        <= '0;
    end else if (grant) begin
      gnt_ch     <= pick_ch;
      last_grant <= pick_ch;
      len        <= pick_len;
      rem        <= pick_len;
    end else if (step && (state == DATA)) begin
      rem <= rem - 9'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TCP_TX_WR   <= 1'b0;
      TCP_TX_DATA <= 8'h00;
    end else begin
      TCP_TX_WR <= emit;
      if (emit) TCP_TX_DATA <= emit_byte;
    end
  end

endmodule

// File: tb/tb_sitcp_tx_mux.sv
// tb/tb_sitcp_tx_mux.sv - directed self-checking bench for sitcp_tx_mux
module tb_sitcp_tx_mux;

  localparam int N_CH  = 4;
  localparam int DEPTH = 1024;
`ifdef SITCP_TX_MUX_HDR_EN
  localparam int HDR_N = 3;
`else
  localparam int HDR_N = 0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              TCP_OPEN_ACK;
  logic [8*N_CH-1:0] CH_DATA;
  logic [N_CH-1:0]   CH_WE;
  logic [N_CH-1:0]   CH_AFULL;
  logic [N_CH-1:0]   CH_OVF;
  logic              TCP_TX_FULL;
  logic              TCP_TX_WR;
  logic [7:0]        TCP_TX_DATA;

  sitcp_tx_mux #(
    .N_CH         (N_CH),
    .DEPTH        (DEPTH),
    .BURST        (256),
    .AFULL_MARGIN (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .TCP_OPEN_ACK (TCP_OPEN_ACK),
    .CH_DATA      (CH_DATA),
    .CH_WE        (CH_WE),
    .CH_AFULL     (CH_AFULL),
    .CH_OVF       (CH_OVF),
    .TCP_TX_FULL  (TCP_TX_FULL),
    .TCP_TX_WR    (TCP_TX_WR),
    .TCP_TX_DATA  (TCP_TX_DATA)
  );

  always #5 CLK = ~CLK;

  int         cyc = 0;
  logic [7:0] got     [$];
  int         got_cyc [$];
  logic [7:0] exp_q   [$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         hold_wr;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (TCP_TX_WR === 1'b1) begin
      got.push_back(TCP_TX_DATA);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic clear_q();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic add_hdr(input int ch, input int len);
    if (HDR_N != 0) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(ch));
      exp_q.push_back(8'(len - 1));
    end
  endtask

  task automatic write_ch(input int ch, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      CH_WE              = '0;
      CH_WE[ch]          = 1'b1;
      CH_DATA[8*ch +: 8] = 8'(base + i);
      @(posedge CLK); #1;
    end
    CH_WE = '0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while ((got.size() < n) && (c < budget)) begin
      @(negedge CLK); #1;
      c++;
    end
    check({tag, "_reached"}, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic settle();
    repeat (10) @(negedge CLK);
    #1;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i),
            (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  function automatic int max_gap();
    int m;
    m = 0;
    for (int i = 1; i < got_cyc.size(); i++) begin
      if (got_cyc[i] - got_cyc[i-1] > m) m = got_cyc[i] - got_cyc[i-1];
    end
    return m;
  endfunction

  initial begin
    RST          = 1'b1;
    TCP_OPEN_ACK = 1'b0;
    CH_DATA      = '0;
    CH_WE        = '0;
    TCP_TX_FULL  = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check("rst_wr",    TCP_TX_WR,   0);
    check("rst_data",  TCP_TX_DATA, 0);
    check("rst_ovf",   CH_OVF,      0);
    check("rst_afull", CH_AFULL,    0);

    RST          = 1'b0;
    TCP_OPEN_ACK = 1'b1;
    repeat (20) @(posedge CLK); #1;
    check("idle_bytes", got.size(), 0);
    check("idle_flags", {CH_OVF, CH_AFULL}, 0);

    // single 5-byte frame on channel 2
    clear_q();
    TCP_TX_FULL = 1'b1;
    write_ch(2, 5, 'h10);
    add_hdr(2, 5);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
    TCP_TX_FULL = 1'b0;
    wait_bytes("single", HDR_N + 5, 100);
    settle();
    compare_q("single");
    check("single_contig", max_gap(), 1);

    // round robin with burst cap: ch0 300 bytes, ch1 10 bytes
    clear_q();
    TCP_TX_FULL = 1'b1;
    for (int i = 0; i < 300; i++) begin
      CH_WE         = (i < 10) ? 4'b0011 : 4'b0001;
      CH_DATA[7:0]  = 8'(i);
      CH_DATA[15:8] = 8'(8'h80 + i);
      @(posedge CLK); #1;
    end
    CH_WE = '0;
    add_hdr(0, 256);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    add_hdr(1, 10);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h80 + i));
    add_hdr(0, 44);
    for (int i = 0; i < 44; i++) exp_q.push_back(8'(i));
    TCP_TX_FULL = 1'b0;
    wait_bytes("rr", 3*HDR_N + 310, 1000);
    settle();
    compare_q("rr");
    check("rr_frame0_contig", got_cyc[HDR_N+255] - got_cyc[0], HDR_N + 255);
    check("rr_gap_le2", 32'(max_gap() <= 2), 1);

    // back-pressure in the middle of the payload
    clear_q();
    TCP_TX_FULL = 1'b1;
    write_ch(1, 40, 'h40);
    add_hdr(1, 40);
    for (int i = 0; i < 40; i++) exp_q.push_back(8'(8'h40 + i));
    TCP_TX_FULL = 1'b0;
    wait_bytes("bp_pre", HDR_N + 10, 100);
    TCP_TX_FULL = 1'b1;
    @(posedge CLK);
    hold_wr = 0;
    repeat (20) begin
      @(negedge CLK);
      if (TCP_TX_WR !== 1'b0) hold_wr++;
    end
    #1;
    check("bp_hold_wr",  hold_wr,    0);
    check("bp_hold_cnt", got.size(), HDR_N + 10);
    TCP_TX_FULL = 1'b0;
    wait_bytes("bp", HDR_N + 40, 200);
    settle();
    compare_q("bp");

    // overflow of channel 3
    clear_q();
    TCP_TX_FULL = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      CH_WE          = 4'b1000;
      CH_DATA[31:24] = 8'(i);
      @(posedge CLK); #1;
      if (i + 1 == DEPTH - 17) check("afull_below", CH_AFULL[3], 0);
      if (i + 1 == DEPTH - 16) check("afull_at",    CH_AFULL[3], 1);
      if (i + 1 == DEPTH)      check("ovf_at_full", CH_OVF[3],   0);
    end
    CH_WE = '0;
    check("ovf_set",    CH_OVF,   4'b1000);
    check("afull_full", CH_AFULL, 4'b1000);
    for (int f = 0; f < 4; f++) begin
      add_hdr(3, 256);
      for (int j = 0; j < 256; j++) exp_q.push_back(8'(j));
    end
    TCP_TX_FULL = 1'b0;
    wait_bytes("ovf", 4*HDR_N + DEPTH, 3000);
    settle();
    compare_q("ovf");
    check("ovf_sticky",  CH_OVF,   4'b1000);
    check("afull_drain", CH_AFULL, 0);

    // flush while byte 100 of a frame is on the output
    clear_q();
    TCP_TX_FULL = 1'b1;
    write_ch(0, 200, 7);
    TCP_TX_FULL = 1'b0;
    wait_bytes("flush_pre", HDR_N + 100, 400);
    check("flush_byte100", got[HDR_N+99], 8'd106);
    TCP_OPEN_ACK = 1'b0;
    @(negedge CLK); #1;
    check("flush_wr_next",  TCP_TX_WR,  0);
    check("flush_ovf_clr",  CH_OVF,     0);
    check("flush_afull",    CH_AFULL,   0);
    check("flush_cnt",      got.size(), HDR_N + 100);
    repeat (3) @(posedge CLK); #1;
    TCP_OPEN_ACK = 1'b1;
    repeat (30) @(posedge CLK); #1;
    check("flush_no_resume", got.size(), HDR_N + 100);

    clear_q();
    TCP_TX_FULL = 1'b1;
    write_ch(1, 3, 'hC0);
    add_hdr(1, 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(8'hC0 + i));
    TCP_TX_FULL = 1'b0;
    wait_bytes("reopen", HDR_N + 3, 100);
    settle();
    compare_q("reopen");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
